serial_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 18 +
 rtl/sub_bit_cell.sv | 18 +
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks that sit beside the
// ripple-carry adder in the datapath.
package arith_pkg;

  // Addend width of the companion ripple-carry adder.
  localparam int ADD_W = 8;

  // Bit counter width: it must hold 0 .. ADD_W, which covers ADD_W+1 serial steps.
  localparam int CNT_W = $clog2(ADD_W + 2);

  // Control states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor computing a - b - bin.
// The cell is purely combinational. Any block that uses it serially supplies
// and stores the borrow itself.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a single column.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial inverse of the ripple-carry adder. It recovers x = sum - y one bit
// per clock, LSB first, and uses a start/ready/done handshake.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W:0]   sum_in,
  input  logic [W-1:0] y_in,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] x_out,
  output logic         ovf
);

  // The count runs 0 .. W, so W+1 bits are processed.
  localparam int CW = $clog2(W + 2);

  sub_state_t   state_q, state_d;
  logic [W:0]   a_sr_q, a_sr_d;
  logic [W:0]   b_sr_q, b_sr_d;
  // Only the W result bits that end up in x_out are kept here. The top
  // difference bit feeds ovf directly on the final step.
  logic [W-1:0] r_sr_q, r_sr_d;
  logic         borrow_q, borrow_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0] x_out_q, x_out_d;
  logic         ovf_q, ovf_d;

  logic         cell_d, cell_bout;

  sub_bit_cell u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state logic: load operands on an accepted start, step one bit per
  // cycle in SHIFT, and capture the result on the last bit.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    x_out_d  = x_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = sum_in;
          b_sr_d   = {1'b0, y_in};
          r_sr_d   = '0;
          borrow_d = 1'b0;
          count_d  = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        borrow_d = cell_bout;
        a_sr_d   = {1'b0, a_sr_q[W:1]};
        b_sr_d   = {1'b0, b_sr_q[W:1]};
        count_d  = count_q + 1'b1;
        if (count_q == CW'(W)) begin
          // Bit W of the difference, together with the final borrow, marks a
          // result outside the W-bit range.
          x_out_d = r_sr_q;
          ovf_d   = cell_d | cell_bout;
          state_d = DONE;
        end else begin
          r_sr_d = {cell_d, r_sr_q[W-1:1]};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any operation in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      x_out_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_sr_q   <= r_sr_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      x_out_q  <= x_out_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake outputs come straight from the state register.
  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
    x_out = x_out_q;
    ovf   = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a vector table, a few random operands checked
// against a reference model, and hand-written busy, back-to-back and
// reset sequences. Expected results flow through a scoreboard queue.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] sum_in;
  logic [7:0] y_in;
  logic       ready;
  logic       done;
  logic [7:0] x_out;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] x;
    logic       o;
  } exp_t;

  typedef struct {
    string      name;
    logic [8:0] sum;
    logic [7:0] y;
    logic [7:0] ex;
    logic       eo;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];

  serial_subtractor #(.W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sum_in (sum_in),
    .y_in   (y_in),
    .ready  (ready),
    .done   (done),
    .x_out  (x_out),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the difference modulo 2^8, flagged when it leaves 0..255.
  function automatic exp_t model(input logic [8:0] s, input logic [7:0] y);
    exp_t e;
    int   si;
    int   yi;
    si  = int'(s);
    yi  = int'(y);
    e.x = 8'((si - yi) & 255);
    e.o = (si < yi) || ((si - yi) >= 256);
    return e;
  endfunction

  // Waits for done. lat counts the cycles after the accepting edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // Pops the scoreboard and compares it with the outputs in the done cycle.
  task automatic compare_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_x"}, 32'(x_out), 32'(e.x));
      chk({name, "_ovf"}, 32'(ovf), 32'(e.o));
    end
  endtask

  // Runs one complete operation. It starts at posedge+1 with the DUT idle and
  // ends one cycle after done.
  task automatic run_op(input string name, input logic [8:0] s, input logic [7:0] y, input exp_t e);
    int g;
    int lat;
    g = 0;
    while (!ready && g < 30) begin
      step();
      g++;
    end
    chk({name, "_ready_before"}, 32'(ready), 32'd1);
    start  = 1'b1;
    sum_in = s;
    y_in   = y;
    step();
    start = 1'b0;
    sb.push_back(e);
    chk({name, "_busy"}, 32'(ready), 32'd0);
    wait_done(lat);
    chk({name, "_latency"}, 32'(lat), 32'd9);
    compare_result(name);
    step();
    chk({name, "_ready_after"}, 32'(ready), 32'd1);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   lat;
    int   ndone;
    bit   hold_ok;
    exp_t e;
    logic [8:0] rs;
    logic [7:0] ry;

    vecs[0] = '{"v200_55",   9'd200, 8'd55,  8'd145, 1'b0};
    vecs[1] = '{"v1ff_ff",   9'h1FF, 8'hFF,  8'h00,  1'b1};
    vecs[2] = '{"v10_20",    9'd10,  8'd20,  8'hF6,  1'b1};
    vecs[3] = '{"v255_0",    9'd255, 8'd0,   8'hFF,  1'b0};

    reset  = 1'b1;
    start  = 1'b0;
    sum_in = '0;
    y_in   = '0;
    step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_ready", 32'(ready), 32'd1);

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      e.x = vecs[i].ex;
      e.o = vecs[i].eo;
      run_op(vecs[i].name, vecs[i].sum, vecs[i].y, e);
    end

    // Random operands against the model
    for (int i = 0; i < 6; i++) begin
      rs = 9'($urandom_range(0, 511));
      ry = 8'($urandom_range(0, 255));
      run_op("rand", rs, ry, model(rs, ry));
    end

    // Back-to-back: 0-0, then 300-100 on the first ready cycle. The first
    // result must hold until the second done.
    e.x = 8'd0;
    e.o = 1'b0;
    run_op("zero", 9'd0, 8'd0, e);
    start  = 1'b1;
    sum_in = 9'd300;
    y_in   = 8'd100;
    step();
    start = 1'b0;
    e.x = 8'd200;
    e.o = 1'b0;
    sb.push_back(e);
    hold_ok = 1'b1;
    lat = 0;
    while (!done && lat < 20) begin
      if (x_out !== 8'd0 || ovf !== 1'b0) hold_ok = 1'b0;
      step();
      lat++;
    end
    chk("b2b_hold", 32'(hold_ok), 32'd1);
    chk("b2b_latency", 32'(lat), 32'd9);
    compare_result("b2b");
    step();

    // start pulses while busy are ignored
    start  = 1'b1;
    sum_in = 9'd200;
    y_in   = 8'd55;
    step();
    start = 1'b0;
    e.x = 8'd145;
    e.o = 1'b0;
    sb.push_back(e);
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3 || c == 9) begin
        start  = 1'b1;
        sum_in = 9'd5;
        y_in   = 8'd1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        ndone++;
        if (ndone == 1) compare_result("busy");
      end
    end
    start = 1'b0;
    chk("busy_done_count", 32'(ndone), 32'd1);
    chk("busy_x_hold", 32'(x_out), 32'd145);

    // Asynchronous reset in the middle of an operation
    start  = 1'b1;
    sum_in = 9'd200;
    y_in   = 8'd55;
    step();
    start = 1'b0;
    sb.push_back('{8'd145, 1'b0});
    for (int c = 0; c < 4; c++) step();
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("async_x", 32'(x_out), 32'd0);
    chk("async_ovf", 32'(ovf), 32'd0);
    chk("async_ready", 32'(ready), 32'd1);
    chk("async_done", 32'(done), 32'd0);
    step();
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done) ndone++;
    end
    chk("async_no_done", 32'(ndone), 32'd0);
    e.x = 8'd99;
    e.o = 1'b0;
    run_op("after_rst", 9'd100, 8'd1, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit in case the DUT hangs
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
